// File: rtl/decoder_pkg.sv
// ============================================================================
// Module      : decoder_pkg
// Description : Opcode constants and output-buffer state type shared by
//               instr_decode_stage and dec_skid_buf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_pkg;

    localparam int OP_NOP       = 0;
    localparam int OP_LOAD_A    = 1;
    localparam int OP_LOAD_B    = 2;
    localparam int OP_ALU_FIRST = 3;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

`default_nettype wire

// File: rtl/dec_skid_buf.sv
// ============================================================================
// Module      : dec_skid_buf
// Description : 2-entry in-order valid/ready buffer; output driven from the
//               head register so the consumer sees only flop outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_skid_buf
    import decoder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    buf_state_t       state_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             w_push;
    logic             w_pop;

    assign w_push = push_valid && push_ready;
    assign w_pop  = pop_valid && pop_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (w_push) begin
                        head_q  <= push_data;
                        state_q <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (w_push && w_pop) begin
                        head_q <= push_data;
                    end else if (w_push) begin
                        tail_q  <= push_data;
                        state_q <= BUF_FULL;
                    end else if (w_pop) begin
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    // Push is impossible here: push_ready is low while FULL.
                    if (w_pop) begin
                        head_q  <= tail_q;
                        state_q <= BUF_ONE;
                    end
                end
                default: state_q <= BUF_EMPTY;
            endcase
        end
    end

    assign push_ready = (state_q != BUF_FULL);
    assign pop_valid  = (state_q != BUF_EMPTY);
    assign pop_data   = head_q;

endmodule

`default_nettype wire

// File: rtl/instr_decode_stage.sv
// ============================================================================
// Module      : instr_decode_stage
// Description : Handshaked instruction decoder with sticky immediates A/B,
//               illegal-opcode detection and a 2-entry output buffer.
//               Define ILLEGAL_COUNT_EN to build the saturating illegal counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode_stage
    import decoder_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 3,
    parameter int OP_MAX = 7
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OP_W+ADDR_W+DATA_W-1:0] in_instr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OP_W-1:0]               out_op,
    output logic [ADDR_W-1:0]             out_addr_a,
    output logic [ADDR_W-1:0]             out_addr_b,
    output logic [DATA_W-1:0]             out_value_a,
    output logic [DATA_W-1:0]             out_value_b,
    output logic                          out_load_a,
    output logic                          out_load_b,
    output logic                          out_alu,
    output logic                          illegal,
    output logic [7:0]                    illegal_count
);

    localparam int INSTR_W = OP_W + ADDR_W + DATA_W;
    localparam int REC_W   = OP_W + 2*ADDR_W + 2*DATA_W + 3;

    logic [OP_W-1:0]   w_op;
    logic [ADDR_W-1:0] w_field_a;
    logic [DATA_W-1:0] w_payload;
    int                w_op_int;
    logic              w_accept;
    logic              w_illegal;
    logic              w_is_load_a;
    logic              w_is_load_b;
    logic              w_is_alu;
    logic              w_is_record;
    logic [ADDR_W-1:0] w_addr_b;
    logic [DATA_W-1:0] value_a_d, value_a_q;
    logic [DATA_W-1:0] value_b_d, value_b_q;
    logic              illegal_q;
    logic [REC_W-1:0]  w_rec_in;
    logic [REC_W-1:0]  w_rec_out;

    assign w_op      = in_instr[INSTR_W-1 -: OP_W];
    assign w_field_a = in_instr[DATA_W +: ADDR_W];
    assign w_payload = in_instr[DATA_W-1:0];
    assign w_op_int  = int'(w_op);

    assign w_accept    = in_valid && in_ready;
    assign w_illegal   = (w_op_int > OP_MAX);
    assign w_is_load_a = (w_op_int == OP_LOAD_A);
    assign w_is_load_b = (w_op_int == OP_LOAD_B);
    assign w_is_alu    = (w_op_int >= OP_ALU_FIRST) && !w_illegal;
    assign w_is_record = (w_op_int != OP_NOP) && !w_illegal;
    assign w_addr_b    = w_is_alu ? w_payload[DATA_W-1 -: ADDR_W] : '0;

    // The record carries the holds as updated by this very instruction.
    assign value_a_d = (w_accept && w_is_load_a) ? w_payload : value_a_q;
    assign value_b_d = (w_accept && w_is_load_b) ? w_payload : value_b_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_a_q <= '0;
            value_b_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            value_a_q <= value_a_d;
            value_b_q <= value_b_d;
            illegal_q <= w_accept && w_illegal;
        end
    end

    assign w_rec_in = {w_op, w_field_a, w_addr_b, value_a_d, value_b_d,
                       w_is_load_a, w_is_load_b, w_is_alu};

    dec_skid_buf #(
        .WIDTH (REC_W)
    ) u_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_valid (in_valid && w_is_record),
        .push_ready (in_ready),
        .push_data  (w_rec_in),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (w_rec_out)
    );

    assign {out_op, out_addr_a, out_addr_b, out_value_a, out_value_b,
            out_load_a, out_load_b, out_alu} = w_rec_out;

    assign illegal = illegal_q;

`ifdef ILLEGAL_COUNT_EN
    logic [7:0] illegal_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal_count_q <= 8'd0;
        end else if (illegal_q && (illegal_count_q != 8'hFF)) begin
            illegal_count_q <= illegal_count_q + 8'd1;
        end
    end

    assign illegal_count = illegal_count_q;
`else
    assign illegal_count = 8'd0;
`endif

endmodule

`default_nettype wire
